// File: rtl/ioctl_rom_router.sv
// ioctl_rom_router: routes data_io ROM bytes into NUM_PORTS sdram toggle req/ack write ports by
// address window, tracks ROM-loaded status and stretches core_reset. Option: IOCTL_ROM_ROUTER_CHECKSUM_EN.
module ioctl_rom_router #(
  parameter int unsigned             NUM_PORTS  = 2,
  parameter int unsigned             IOCTL_AW   = 25,
  parameter int unsigned             PORT_AW    = 23,
  parameter logic [NUM_PORTS*32-1:0] BASE       = {32'h08000, 32'h00000},
  parameter logic [NUM_PORTS*32-1:0] SIZE       = {32'h08000, 32'h08000},
  parameter logic [7:0]              ROM_INDEX  = 8'h00,
  parameter int unsigned             RESET_HOLD = 16
) (
  input  logic                         clk_sys,
  input  logic                         res_n,
  input  logic                         ioctl_download,
  input  logic [7:0]                   ioctl_index,
  input  logic                         ioctl_wr,
  input  logic [IOCTL_AW-1:0]          ioctl_addr,
  input  logic [7:0]                   ioctl_dout,
  output logic [NUM_PORTS-1:0]         port_req,
  input  logic [NUM_PORTS-1:0]         port_ack,
  output logic [NUM_PORTS-1:0]         port_we,
  output logic [NUM_PORTS*PORT_AW-1:0] port_a,
  output logic [NUM_PORTS*2-1:0]       port_ds,
  output logic [NUM_PORTS*16-1:0]      port_d,
  input  logic                         reset_req,
  output logic                         rom_loaded,
  output logic                         core_reset,
  output logic                         overrun
`ifdef IOCTL_ROM_ROUTER_CHECKSUM_EN
  ,
  output logic [15:0]                  rom_sum,
  output logic                         sum_valid
`endif
);

  localparam int unsigned HOLD_W = (RESET_HOLD > 0) ? $clog2(RESET_HOLD + 1) : 1;

  typedef enum logic [1:0] {
    CR_ASSERT,
    CR_COUNT,
    CR_RELEASED
  } cr_state_t;

  logic                              download_q;
  logic                              wr_q;
  logic                              rom_active_q;
  logic                              wr_rise;
  logic                              dl_rise;
  logic                              dl_fall;
  logic                              accept;
  logic [31:0]                       addr32;
  logic [31:0]                       offset [NUM_PORTS];
  logic [NUM_PORTS-1:0]              hit;
  logic [NUM_PORTS-1:0]              take;
  logic [NUM_PORTS-1:0]              busy;

  logic [NUM_PORTS-1:0]              req_q;
  logic [NUM_PORTS-1:0][PORT_AW-1:0] a_q;
  logic [NUM_PORTS-1:0][1:0]         ds_q;
  logic [NUM_PORTS-1:0][15:0]        d_q;
  logic                              rom_loaded_q;
  logic                              overrun_q;

  cr_state_t                         cr_state;
  cr_state_t                         cr_state_n;
  logic [HOLD_W-1:0]                 hold_cnt;
  logic [HOLD_W-1:0]                 hold_cnt_n;
  logic                              cause;

  assign wr_rise = ioctl_wr & ~wr_q;
  assign dl_rise = ioctl_download & ~download_q;
  assign dl_fall = ~ioctl_download & download_q;
  // Gate on the registered download/index so a write landing with the download fall is kept.
  assign accept  = wr_rise & rom_active_q;
  assign addr32  = 32'(ioctl_addr);
  assign busy    = req_q ^ port_ack;
  assign take    = hit & {NUM_PORTS{accept}};

  always_comb begin
    hit    = '0;
    offset = '{default: '0};
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      offset[i] = addr32 - BASE[32*i +: 32];
      hit[i]    = (addr32 >= BASE[32*i +: 32]) && (offset[i] < SIZE[32*i +: 32]);
    end
  end

  always_ff @(posedge clk_sys or negedge res_n) begin
    if (!res_n) begin
      download_q   <= 1'b0;
      wr_q         <= 1'b0;
      rom_active_q <= 1'b0;
    end else begin
      download_q   <= ioctl_download;
      wr_q         <= ioctl_wr;
      rom_active_q <= ioctl_download && (ioctl_index == ROM_INDEX);
    end
  end

  always_ff @(posedge clk_sys or negedge res_n) begin
    if (!res_n) begin
      req_q <= '0;
      a_q   <= '0;
      ds_q  <= '0;
      d_q   <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        if (take[i]) begin
          req_q[i] <= ~req_q[i];
          a_q[i]   <= PORT_AW'(offset[i] >> 1);
          ds_q[i]  <= {ioctl_addr[0], ~ioctl_addr[0]};
          d_q[i]   <= {ioctl_dout, ioctl_dout};
        end
      end
    end
  end

  always_ff @(posedge clk_sys or negedge res_n) begin
    if (!res_n) begin
      rom_loaded_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      if (dl_rise) begin
        overrun_q <= 1'b0;
      end else if (|(take & busy)) begin
        overrun_q <= 1'b1;
      end
      if (dl_rise && (ioctl_index == ROM_INDEX)) begin
        rom_loaded_q <= 1'b0;
      end else if (dl_fall && rom_active_q) begin
        rom_loaded_q <= 1'b1;
      end
    end
  end

  assign cause = reset_req | ioctl_download | ~rom_loaded_q;

  always_ff @(posedge clk_sys or negedge res_n) begin
    if (!res_n) begin
      cr_state <= CR_ASSERT;
      hold_cnt <= HOLD_W'(RESET_HOLD);
    end else begin
      cr_state <= cr_state_n;
      hold_cnt <= hold_cnt_n;
    end
  end

  always_comb begin
    cr_state_n = cr_state;
    hold_cnt_n = hold_cnt;
    if (cause) begin
      cr_state_n = CR_ASSERT;
      hold_cnt_n = HOLD_W'(RESET_HOLD);
    end else begin
      case (cr_state)
        CR_ASSERT, CR_COUNT: begin
          if (hold_cnt == '0) begin
            cr_state_n = CR_RELEASED;
          end else begin
            cr_state_n = CR_COUNT;
            hold_cnt_n = hold_cnt - HOLD_W'(1);
          end
        end
        CR_RELEASED: cr_state_n = CR_RELEASED;
        default:     cr_state_n = CR_ASSERT;
      endcase
    end
  end

  // port_we comes from the same registered qualifier that gates writes, so it is 0 during reset.
  assign port_req   = req_q;
  assign port_we    = {NUM_PORTS{rom_active_q}};
  assign port_a     = a_q;
  assign port_ds    = ds_q;
  assign port_d     = d_q;
  assign rom_loaded = rom_loaded_q;
  assign overrun    = overrun_q;
  assign core_reset = (cr_state != CR_RELEASED);

`ifdef IOCTL_ROM_ROUTER_CHECKSUM_EN
  logic [15:0] sum_q;

  always_ff @(posedge clk_sys or negedge res_n) begin
    if (!res_n) begin
      sum_q <= '0;
    end else if (dl_rise && (ioctl_index == ROM_INDEX)) begin
      sum_q <= '0;
    end else if (accept) begin
      sum_q <= sum_q + 16'(ioctl_dout);
    end
  end

  assign rom_sum   = sum_q;
  assign sum_valid = rom_loaded_q;
`endif

endmodule

// File: tb/tb_ioctl_rom_router.sv
// Randomized scoreboard bench for ioctl_rom_router: the driver pushes expected sdram writes,
// a negedge monitor pops and compares on every port_req toggle.
`timescale 1ns/1ps
module tb_ioctl_rom_router;

  localparam int unsigned NP       = 2;
  localparam int unsigned IOCTL_AW = 25;
  localparam int unsigned PORT_AW  = 23;
  localparam int unsigned HOLD     = 16;
  localparam logic [7:0]  ROM      = 8'h00;

  int unsigned win_base [NP] = '{32'h00000, 32'h08000};
  int unsigned win_size [NP] = '{32'h08000, 32'h08000};

  logic                   clk_sys        = 1'b0;
  logic                   res_n          = 1'b0;
  logic                   ioctl_download = 1'b0;
  logic [7:0]             ioctl_index    = 8'h00;
  logic                   ioctl_wr       = 1'b0;
  logic [IOCTL_AW-1:0]    ioctl_addr     = '0;
  logic [7:0]             ioctl_dout     = 8'h00;
  logic [NP-1:0]          port_req;
  logic [NP-1:0]          port_ack       = '0;
  logic [NP-1:0]          port_we;
  logic [NP*PORT_AW-1:0]  port_a;
  logic [NP*2-1:0]        port_ds;
  logic [NP*16-1:0]       port_d;
  logic                   reset_req      = 1'b0;
  logic                   rom_loaded;
  logic                   core_reset;
  logic                   overrun;
`ifdef IOCTL_ROM_ROUTER_CHECKSUM_EN
  logic [15:0]            rom_sum;
  logic                   sum_valid;
`endif

  ioctl_rom_router #(
    .NUM_PORTS (NP),
    .IOCTL_AW  (IOCTL_AW),
    .PORT_AW   (PORT_AW),
    .BASE      ({32'h08000, 32'h00000}),
    .SIZE      ({32'h08000, 32'h08000}),
    .ROM_INDEX (ROM),
    .RESET_HOLD(HOLD)
  ) dut (
    .clk_sys       (clk_sys),
    .res_n         (res_n),
    .ioctl_download(ioctl_download),
    .ioctl_index   (ioctl_index),
    .ioctl_wr      (ioctl_wr),
    .ioctl_addr    (ioctl_addr),
    .ioctl_dout    (ioctl_dout),
    .port_req      (port_req),
    .port_ack      (port_ack),
    .port_we       (port_we),
    .port_a        (port_a),
    .port_ds       (port_ds),
    .port_d        (port_d),
    .reset_req     (reset_req),
    .rom_loaded    (rom_loaded),
    .core_reset    (core_reset),
    .overrun       (overrun)
`ifdef IOCTL_ROM_ROUTER_CHECKSUM_EN
    ,
    .rom_sum       (rom_sum),
    .sum_valid     (sum_valid)
`endif
  );

  always #5 clk_sys = ~clk_sys;

  int unsigned cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  typedef struct {
    int unsigned port;
    int unsigned word;
    logic [1:0]  ds;
    logic [15:0] d;
    int unsigned at;
  } txn_t;

  txn_t exp_q[$];

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // reference model state
  logic [NP-1:0] req_m = '0;
  bit            rl_m  = 1'b0;
  bit            ovr_m = 1'b0;
  logic [15:0]   sum_m = '0;
  bit            dl_m  = 1'b0;
  logic [7:0]    idx_m = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // sdram side: ack echoes req three cycles later unless frozen
  logic [NP-1:0] ack_d0 = '0;
  logic [NP-1:0] ack_d1 = '0;
  bit            ack_freeze = 1'b0;
  always @(negedge clk_sys) begin
    if (!res_n) begin
      ack_d0   = '0;
      ack_d1   = '0;
      port_ack = '0;
    end else begin
      if (!ack_freeze) port_ack = ack_d1;
      ack_d1 = ack_d0;
      ack_d0 = port_req;
    end
  end

  logic [NP-1:0] last_req = '0;
  always @(negedge clk_sys) begin
    int   idx;
    txn_t t;
    if (!res_n) begin
      last_req = '0;
      exp_q.delete();
    end else begin
      for (int unsigned p = 0; p < NP; p++) begin
        if (port_req[p] !== last_req[p]) begin
          idx = -1;
          for (int k = 0; k < exp_q.size(); k++)
            if (idx < 0 && exp_q[k].port == p) idx = k;
          if (idx < 0) begin
            check($sformatf("unexpected_req%0d", p), 32'(port_req[p]), 32'(last_req[p]));
          end else begin
            t = exp_q[idx];
            exp_q.delete(idx);
            check($sformatf("port_a%0d", p), 32'(port_a[p*PORT_AW +: PORT_AW]), t.word);
            check($sformatf("port_ds%0d", p), 32'(port_ds[p*2 +: 2]), 32'(t.ds));
            check($sformatf("port_d%0d", p), 32'(port_d[p*16 +: 16]), 32'(t.d));
            check($sformatf("req_latency%0d", p), cyc, t.at);
          end
        end
      end
      last_req = port_req;
    end
  end

  task automatic send(input int unsigned addr, input logic [7:0] data, input bit drop_dl);
    txn_t t;
    @(negedge clk_sys); #1;
    if (dl_m && (idx_m == ROM)) begin
      sum_m = sum_m + 16'(data);
      for (int unsigned p = 0; p < NP; p++) begin
        if (addr >= win_base[p] && addr < win_base[p] + win_size[p]) begin
          if (req_m[p] != port_ack[p]) ovr_m = 1'b1;
          req_m[p] = ~req_m[p];
          t.port = p;
          t.word = (addr - win_base[p]) / 2;
          t.ds   = (addr % 2 == 1) ? 2'b10 : 2'b01;
          t.d    = {data, data};
          t.at   = cyc + 1;
          exp_q.push_back(t);
        end
      end
    end
    ioctl_addr = IOCTL_AW'(addr);
    ioctl_dout = data;
    ioctl_wr   = 1'b1;
    if (drop_dl) begin
      ioctl_download = 1'b0;
      if (idx_m == ROM) rl_m = 1'b1;
      dl_m = 1'b0;
    end
    @(negedge clk_sys); #1;
    ioctl_wr = 1'b0;
    repeat (3) @(negedge clk_sys);
  endtask

  task automatic start_dl(input logic [7:0] idx);
    @(negedge clk_sys); #1;
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    ovr_m = 1'b0;
    if (idx == ROM) begin
      rl_m  = 1'b0;
      sum_m = '0;
    end
    dl_m  = 1'b1;
    idx_m = idx;
    repeat (2) @(negedge clk_sys);
  endtask

  task automatic end_dl();
    @(negedge clk_sys); #1;
    ioctl_download = 1'b0;
    if (idx_m == ROM) rl_m = 1'b1;
    dl_m = 1'b0;
    repeat (2) @(negedge clk_sys);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req"},        32'(port_req),   0);
    check({tag, "_we"},         32'(port_we),    0);
    check({tag, "_a"},          32'(port_a[31:0]), 0);
    check({tag, "_ds"},         32'(port_ds),    0);
    check({tag, "_d"},          port_d[31:0],    0);
    check({tag, "_rom_loaded"}, 32'(rom_loaded), 0);
    check({tag, "_overrun"},    32'(overrun),    0);
    check({tag, "_core_reset"}, 32'(core_reset), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk_sys);
    check_reset_vals("reset");
    @(negedge clk_sys); #1;
    res_n = 1'b1;

    // main ROM stream
    start_dl(ROM);
    check("we_rom", 32'(port_we), 32'((1 << NP) - 1));
    check("core_reset_dl", 32'(core_reset), 1);
    send(32'h00005, 8'hA7, 1'b0);
    for (int unsigned a = 0; a < 64; a++) send(a, 8'(a), 1'b0);
    for (int unsigned a = 32'h07FFC; a < 32'h08004; a++) send(a, 8'($urandom), 1'b0);
    send(32'h0FFFE, 8'($urandom), 1'b0);
    send(32'h0FFFF, 8'($urandom), 1'b0);
    send(32'h10000, 8'($urandom), 1'b0);
    send(32'h10001, 8'($urandom), 1'b0);
    for (int n = 0; n < 1200; n++) send($urandom_range(0, 32'h10FFF), 8'($urandom), 1'b0);
    send(32'h08000, 8'($urandom), 1'b1);  // write together with download fall
    repeat (2) @(negedge clk_sys);
    check("overrun_stream", 32'(overrun), 32'(ovr_m));
    check("rom_loaded_end", 32'(rom_loaded), 32'(rl_m));
`ifdef IOCTL_ROM_ROUTER_CHECKSUM_EN
    check("rom_sum_stream", 32'(rom_sum), 32'(sum_m));
    check("sum_valid_stream", 32'(sum_valid), 32'(rl_m));
`endif

    repeat (HOLD + 4) @(negedge clk_sys);
    check("core_reset_released", 32'(core_reset), 0);

    // one-cycle reset_req pulse
    @(negedge clk_sys); #1;
    reset_req = 1'b1;
    @(negedge clk_sys); #1;
    reset_req = 1'b0;
    for (int unsigned k = 1; k <= HOLD + 1; k++) begin
      @(posedge clk_sys);
      @(negedge clk_sys);
      check($sformatf("core_reset_hold_k%0d", k), 32'(core_reset), 32'(k <= HOLD));
    end

    // stray strobes outside a download
    send(32'h00100, 8'h55, 1'b0);
    send(32'h08100, 8'hAA, 1'b0);

    // foreign index download
    start_dl(8'h01);
    check("we_other_idx", 32'(port_we), 0);
    for (int n = 0; n < 20; n++) send($urandom_range(0, 32'h0FFFF), 8'($urandom), 1'b0);
    end_dl();
    check("rom_loaded_other_idx", 32'(rom_loaded), 32'(rl_m));

    // overrun with ack held
    start_dl(ROM);
    check("rom_loaded_cleared", 32'(rom_loaded), 32'(rl_m));
    ack_freeze = 1'b1;
    send($urandom_range(0, 32'h07FFF), 8'($urandom), 1'b0);
    send($urandom_range(0, 32'h07FFF), 8'($urandom), 1'b0);
    check("overrun_set", 32'(overrun), 32'(ovr_m));
    ack_freeze = 1'b0;
    repeat (4) @(negedge clk_sys);
    end_dl();
    check("overrun_sticky", 32'(overrun), 32'(ovr_m));
    start_dl(ROM);
    check("overrun_cleared", 32'(overrun), 32'(ovr_m));

    // reset in the middle of a stream with a pending handshake
    ack_freeze = 1'b1;
    send($urandom_range(0, 32'h07FFF), 8'($urandom), 1'b0);
    send($urandom_range(0, 32'h07FFF), 8'($urandom), 1'b0);
    check("overrun_again", 32'(overrun), 32'(ovr_m));
    @(negedge clk_sys); #1;
    res_n = 1'b0;
    ioctl_download = 1'b0;
    ioctl_wr = 1'b0;
    req_m = '0; rl_m = 1'b0; ovr_m = 1'b0; sum_m = '0; dl_m = 1'b0;
    ack_freeze = 1'b0;
    @(negedge clk_sys);
    check_reset_vals("midrst");
    @(negedge clk_sys); #1;
    res_n = 1'b1;

    start_dl(ROM);
    send($urandom_range(0, 32'h0FFFF), 8'h01, 1'b0);
    send($urandom_range(0, 32'h0FFFF), 8'hFF, 1'b0);
    send($urandom_range(32'h10000, 32'h10FFF), 8'h10, 1'b0);
    end_dl();
    check("rom_loaded_reload", 32'(rom_loaded), 32'(rl_m));
`ifdef IOCTL_ROM_ROUTER_CHECKSUM_EN
    check("rom_sum_small", 32'(rom_sum), 32'(sum_m));
    check("sum_valid_small", 32'(sum_valid), 32'(rl_m));
`endif

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk_sys);
    check("scoreboard_drain", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
